// File: rtl/light_dance_pkg.sv
// Shared constants and types for the light-dance lamp display.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package light_dance_pkg;

  localparam int LAMPS      = 8;
  localparam int PWM_W_DFLT = 4;
  localparam int LVL_MAX_DFLT = (1 << PWM_W_DFLT) - 1;
  localparam int DECAY_DFLT = 1;

  typedef logic [PWM_W_DFLT-1:0] level_t;

endpackage

// File: rtl/light_dance_display_lamp_fader.sv
// One lamp: holds a fade-out brightness level and turns it into a PWM drive bit.
// Latency: level updates at the tick edge; lamp reflects it one clock later.
// Backpressure: none; enable=0 holds the level and blanks the lamp.
// Ports: clk, arst (async active-low), tick (frame strobe), bit_in (pattern bit),
//        pwm_cnt (shared PWM phase), enable, lamp (registered drive, 1 = lit).
module lamp_fader
  import light_dance_pkg::*;
#(
  parameter int PWM_W = PWM_W_DFLT,
  parameter int DECAY = DECAY_DFLT
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             tick,
  input  logic             bit_in,
  input  logic [PWM_W-1:0] pwm_cnt,
  input  logic             enable,
  output logic             lamp
);

  localparam logic [PWM_W-1:0] LVL_MAX = '1;
  localparam logic [PWM_W-1:0] DEC_V   = PWM_W'(DECAY);

  logic [PWM_W-1:0] r_level;
  logic             r_lamp;

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_level <= '0;
      r_lamp  <= 1'b0;
    end else begin
      // tick already includes enable, so levels freeze while disabled
      if (tick) begin
        if (bit_in)
          r_level <= LVL_MAX;
        else if (r_level >= DEC_V)
          r_level <= r_level - DEC_V;
        else
          r_level <= '0;
      end
      // Compare uses the pre-edge level, so a new level shows up one cycle later
      r_lamp <= enable & (r_level > pwm_cnt);
    end
  end

  assign lamp = r_lamp;

endmodule

// File: rtl/light_dance_display.sv
// Decimates the shift-register pattern into frames and drives eight faded PWM lamps.
// Latency: frame/frame_vld one clock after the tick edge; lamp one clock after a level change.
// Backpressure: none; enable=0 freezes prescaler, PWM and levels and blanks the lamps.
// Ports: clk, arst (async active-low), enable, div_val (frame period - 1),
//        qdata (pattern in), frame/frame_vld (captured pattern + pulse), lamp (PWM drive).
module light_dance_display
  import light_dance_pkg::*;
#(
  parameter int DIV_W = 16,
  parameter int PWM_W = PWM_W_DFLT,
  parameter int DECAY = DECAY_DFLT
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             enable,
  input  logic [DIV_W-1:0] div_val,
  input  logic [LAMPS-1:0] qdata,
  output logic [LAMPS-1:0] frame,
  output logic             frame_vld,
  output logic [LAMPS-1:0] lamp
);

  // PWM counter wraps after LVL_MAX-1 so the period is LVL_MAX cycles and
  // a full-scale level is lit on every phase.
  localparam logic [PWM_W-1:0] PWM_LAST = PWM_W'((1 << PWM_W) - 2);

  logic [DIV_W-1:0] r_div_cnt;
  logic [PWM_W-1:0] r_pwm_cnt;
  logic [LAMPS-1:0] r_frame;
  logic             r_frame_vld;
  logic             w_tick;

  // >= rather than == so shrinking div_val below the count ticks at once
  assign w_tick = enable & (r_div_cnt >= div_val);

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_div_cnt   <= '0;
      r_pwm_cnt   <= '0;
      r_frame     <= '0;
      r_frame_vld <= 1'b0;
    end else begin
      if (enable) begin
        r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
        r_pwm_cnt <= (r_pwm_cnt == PWM_LAST) ? '0 : r_pwm_cnt + 1'b1;
      end
      if (w_tick)
        r_frame <= qdata;
      r_frame_vld <= w_tick;
    end
  end

  for (genvar gi = 0; gi < LAMPS; gi++) begin : g_lamp
    lamp_fader #(
      .PWM_W (PWM_W),
      .DECAY (DECAY)
    ) u_fader (
      .clk     (clk),
      .arst    (arst),
      .tick    (w_tick),
      .bit_in  (qdata[gi]),
      .pwm_cnt (r_pwm_cnt),
      .enable  (enable),
      .lamp    (lamp[gi])
    );
  end

  assign frame     = r_frame;
  assign frame_vld = r_frame_vld;

endmodule

// File: tb/tb_light_dance_display.sv
// Directed bench for light_dance_display: reset, decimation, fade, enable gating,
// div_val shrink and asynchronous reset during a fade.
module tb_light_dance_display;

  logic        clk;
  logic        arst;
  logic        enable;
  logic [15:0] div_val;
  logic [7:0]  qdata;
  logic [7:0]  frame;
  logic        frame_vld;
  logic [7:0]  lamp;

  int n_vec;
  int n_bad;

  light_dance_display dut (
    .clk       (clk),
    .arst      (arst),
    .enable    (enable),
    .div_val   (div_val),
    .qdata     (qdata),
    .frame     (frame),
    .frame_vld (frame_vld),
    .lamp      (lamp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle 1ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [15:0] dv, input logic [7:0] qd, input logic en);
    div_val = dv;
    qdata   = qd;
    enable  = en;
    @(posedge clk);
    #2 arst = 1'b0;
    #4 arst = 1'b1;
  endtask

  task automatic test_reset();
    div_val = 16'd3;
    qdata   = 8'hFF;
    enable  = 1'b1;
    arst    = 1'b0;
    repeat (3) step();
    n_vec++;
    if (frame !== 8'h00 || frame_vld !== 1'b0 || lamp !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_state: frame=%h vld=%b lamp=%h, want 00/0/00", frame, frame_vld, lamp);
    end
    #2 arst = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      n_vec++;
      if (lamp !== 8'h00) begin
        n_bad++;
        $display("FAIL reset_lamp_dark edge%0d: lamp=%h want 00", k, lamp);
      end
    end
    n_vec++;
    if (frame_vld !== 1'b1 || frame !== 8'hFF) begin
      n_bad++;
      $display("FAIL reset_first_tick: vld=%b frame=%h want 1/FF", frame_vld, frame);
    end
    step();
    n_vec++;
    if (lamp !== 8'hFF) begin
      n_bad++;
      $display("FAIL reset_first_lit: lamp=%h want FF", lamp);
    end
  endtask

  task automatic test_decimation();
    logic [7:0] prev;
    logic       exp_vld;
    do_reset(16'd3, 8'h00, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      qdata = 8'(k * 7 + 3);
      prev  = qdata;
      step();
      exp_vld = (k % 4 == 0);
      n_vec++;
      if (frame_vld !== exp_vld || (exp_vld && frame !== prev)) begin
        n_bad++;
        $display("FAIL decim_div3 edge%0d: vld=%b frame=%h want vld=%b frame=%h",
                 k, frame_vld, frame, exp_vld, prev);
      end
    end
    div_val = 16'd0;
    for (int k = 1; k <= 5; k++) begin
      qdata = 8'hC0 + 8'(k);
      prev  = qdata;
      step();
      n_vec++;
      if (frame_vld !== 1'b1 || frame !== prev) begin
        n_bad++;
        $display("FAIL decim_div0 edge%0d: vld=%b frame=%h want 1/%h", k, frame_vld, frame, prev);
      end
    end
  endtask

  task automatic test_fade();
    int         cnt;
    int         exp_cnt;
    logic [7:0] other;
    // 15-cycle frames line up with the 15-cycle PWM period, so the number of
    // lit cycles per frame equals the level.
    do_reset(16'd14, 8'h01, 1'b1);
    repeat (15) step();
    n_vec++;
    if (frame_vld !== 1'b1 || frame !== 8'h01) begin
      n_bad++;
      $display("FAIL fade_first_tick: vld=%b frame=%h want 1/01", frame_vld, frame);
    end
    qdata = 8'h00;
    for (int f = 0; f < 18; f++) begin
      cnt   = 0;
      other = 8'h00;
      repeat (15) begin
        step();
        cnt   = cnt + int'(lamp[0]);
        other = other | {lamp[7:1], 1'b0};
      end
      exp_cnt = (f <= 15) ? 15 - f : 0;
      n_vec++;
      if (cnt != exp_cnt || other !== 8'h00) begin
        n_bad++;
        $display("FAIL fade_duty frame%0d: lit=%0d others=%h want lit=%0d others=00",
                 f, cnt, other, exp_cnt);
      end
    end
  endtask

  task automatic test_enable_gating();
    logic exp_vld;
    do_reset(16'd9, 8'hAA, 1'b1);
    repeat (13) step();
    n_vec++;
    if (lamp !== 8'hAA || frame !== 8'hAA) begin
      n_bad++;
      $display("FAIL gate_before: lamp=%h frame=%h want AA/AA", lamp, frame);
    end
    enable = 1'b0;
    qdata  = 8'h55;
    for (int k = 1; k <= 10; k++) begin
      step();
      n_vec++;
      if (lamp !== 8'h00 || frame_vld !== 1'b0 || frame !== 8'hAA) begin
        n_bad++;
        $display("FAIL gate_off cycle%0d: lamp=%h vld=%b frame=%h want 00/0/AA",
                 k, lamp, frame_vld, frame);
      end
    end
    enable = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      exp_vld = (k == 7);
      n_vec++;
      if (frame_vld !== exp_vld) begin
        n_bad++;
        $display("FAIL gate_resume_vld edge%0d: vld=%b want %b", k, frame_vld, exp_vld);
      end
      if (k == 1) begin
        n_vec++;
        if (lamp !== 8'hAA) begin
          n_bad++;
          $display("FAIL gate_resume_lamp: lamp=%h want AA", lamp);
        end
      end
      if (k == 7) begin
        n_vec++;
        if (frame !== 8'h55) begin
          n_bad++;
          $display("FAIL gate_resume_frame: frame=%h want 55", frame);
        end
      end
    end
  endtask

  task automatic test_div_shrink();
    logic exp_vld;
    do_reset(16'd20, 8'h3C, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      step();
      n_vec++;
      if (frame_vld !== 1'b0) begin
        n_bad++;
        $display("FAIL shrink_pre edge%0d: vld=%b want 0", k, frame_vld);
      end
    end
    div_val = 16'd5;
    for (int k = 11; k <= 23; k++) begin
      step();
      exp_vld = (k == 11) || (k == 17) || (k == 23);
      n_vec++;
      if (frame_vld !== exp_vld) begin
        n_bad++;
        $display("FAIL shrink_post edge%0d: vld=%b want %b", k, frame_vld, exp_vld);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset(16'd0, 8'hFF, 1'b1);
    repeat (3) step();
    n_vec++;
    if (lamp !== 8'hFF || frame_vld !== 1'b1) begin
      n_bad++;
      $display("FAIL areset_setup: lamp=%h vld=%b want FF/1", lamp, frame_vld);
    end
    #2 arst = 1'b0;
    #1;
    n_vec++;
    if (lamp !== 8'h00 || frame !== 8'h00 || frame_vld !== 1'b0) begin
      n_bad++;
      $display("FAIL areset_immediate: lamp=%h frame=%h vld=%b want 00/00/0", lamp, frame, frame_vld);
    end
    qdata   = 8'h00;
    div_val = 16'd3;
    #2 arst = 1'b1;
    // With levels cleared, a zero pattern keeps every lamp dark.
    for (int k = 1; k <= 8; k++) begin
      step();
      n_vec++;
      if (lamp !== 8'h00) begin
        n_bad++;
        $display("FAIL areset_levels edge%0d: lamp=%h want 00", k, lamp);
      end
    end
  endtask

  initial begin
    n_vec   = 0;
    n_bad   = 0;
    arst    = 1'b0;
    enable  = 1'b0;
    div_val = '0;
    qdata   = '0;
    test_reset();
    test_decimation();
    test_fade();
    test_enable_gating();
    test_div_shrink();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
